mac_accum_8bit: RTL

MAC_ACCUM_8BIT -- requirements
Module: mac_accum_8bit

---
 rtl/mac_accum_8bit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mac_accum_8bit.sv
// -----------------------------------------------------------------------------
// mac_accum_8bit
//
// Accumulates NTERMS unsigned 8-bit products into a saturating ACC_W-bit sum
// and presents the completed sum to a downstream consumer.
//
// Handshakes (both directions use the same rule): a transfer happens on a
// rising clk edge where the producer's valid and the consumer's ready are both
// 1. Valid never depends on ready. Here the block is the consumer on the
// prod_* side and the producer on the acc_* side.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   prod       : unsigned product from the upstream multiplier
//   prod_valid : prod is valid this cycle
//   prod_ready : block accepts prod this cycle (1 while collecting)
//   clear      : synchronous abort of the running sum (ignored while holding)
//   acc_data   : completed sum, retained after it has been taken
//   acc_ovf    : completed sum saturated
//   acc_valid  : acc_data / acc_ovf are valid
//   acc_ready  : downstream consumer takes the result
//   state_dbg  : current FSM state (0 = ACCUM, 1 = HOLD)
// -----------------------------------------------------------------------------
module mac_accum_8bit #(
  parameter int NTERMS = 4,
  parameter int ACC_W  = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_data,
  output logic             acc_ovf,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             state_dbg
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam logic [7:0]       LAST_CNT = 8'(NTERMS - 1);
  localparam logic [ACC_W-1:0] SAT_MAX  = '1;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] acc_data_q, acc_data_d;
  logic             acc_ovf_q, acc_ovf_d;

  // One extra bit on the adder makes the carry out the overflow flag.
  logic [ACC_W:0]   sum_ext;
  logic             add_ovf;
  logic [ACC_W-1:0] sum_sat;

  always_comb begin
    sum_ext = {1'b0, sum_q} + (ACC_W + 1)'(prod);
    add_ovf = sum_ext[ACC_W];
    sum_sat = add_ovf ? SAT_MAX : sum_ext[ACC_W-1:0];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    acc_data_d = acc_data_q;
    acc_ovf_d  = acc_ovf_q;

    case (state_q)
      ST_ACCUM: begin
        // clear takes priority over any product, including the final one,
        // so an aborted batch never produces a result.
        if (clear) begin
          sum_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (prod_valid) begin
          if (cnt_q == LAST_CNT) begin
            acc_data_d = sum_sat;
            acc_ovf_d  = ovf_q | add_ovf;
            ovf_d      = ovf_q | add_ovf;
            sum_d      = '0;
            cnt_d      = '0;
            state_d    = ST_HOLD;
          end else begin
            sum_d = sum_sat;
            cnt_d = cnt_q + 8'd1;
            ovf_d = ovf_q | add_ovf;
          end
        end
      end

      ST_HOLD: begin
        // Result held stable until taken; the product port stays closed in
        // the handshake cycle, so the next batch starts one cycle later.
        if (acc_ready) begin
          ovf_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACCUM;
      sum_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      acc_data_q <= '0;
      acc_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      acc_data_q <= acc_data_d;
      acc_ovf_q  <= acc_ovf_d;
    end
  end

  // Handshake outputs come straight from the state register, so they are
  // glitch-free and take their reset values as soon as rst_n falls.
  always_comb begin
    prod_ready = (state_q == ST_ACCUM);
    acc_valid  = (state_q == ST_HOLD);
    acc_data   = acc_data_q;
    acc_ovf    = acc_ovf_q;
    state_dbg  = state_q;
  end

endmodule
